branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage dynamic branch predictor for the five-stage RISC-V pipeline. It is the producer of the `predictor` bit that the EX-stage hazard/flush logic later checks against the resolved outcome. It holds a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB), answers IF-stage lookups with zero latency, and is trained by EX-stage resolution. A saturating mispredict counter is kept for performance reporting.

## Interface
- `ENTRIES`, 16: table depth; power of two, minimum 4. `IDX = log2(ENTRIES)`.
- `CNT_W`, 16: mispredict counter width.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `if_pc`  in  32  fetch PC to predict
- `pred_taken`  out  1  predicted taken; travels down the pipe as `predictor`
- `pred_target`  out  32  predicted next PC, valid when `pred_taken`=1
- `ex_valid`  in  1  EX holds a real, non-bubbled instruction
- `ex_opcode`  in  7  EX instruction opcode
- `ex_pc`  in  32  PC of the EX instruction
- `ex_taken`  in  1  resolved direction (1 for JAL/JALR)
- `ex_target`  in  32  resolved target address
- `ex_flush`  in  1  mispredict flush raised by hazard logic for this EX instruction
- `mispredict_cnt`  out  CNT_W  saturating count of flushes

## Operation
- Index = `pc[IDX+1:2]`; tag = `pc[31:IDX+2]`. Per entry: `valid`, `tag`, `kind` (0 branch, 1 jump), `ctr[1:0]`, `target[31:0]`.
- Lookup: hit = `valid && tag match`. `pred_taken` = hit && (`kind` || `ctr[1]`). `pred_target` = entry target on hit, else `if_pc + 4`.
- Update applies only when `ex_valid`=1. Opcodes other than B-type 7'b1100011, JAL 7'b1101111, and JALR 7'b1100111 are ignored.
- Update for B-type on a hit:
  - Taken: `ctr` increments, saturating at 2'b11; `target` is set to `ex_target`.
  - Not taken: `ctr` decrements, saturating at 2'b00; `target` is unchanged.
- Update for B-type on a miss:
  - Taken: allocate the entry with `valid`=1, new tag, `kind`=0, `ctr`=2'b10, `target`=`ex_target`. This replaces any previous occupant.
  - Not taken: no allocation and no state change.
- JAL/JALR, hit or miss: write the entry with `valid`=1, tag, `kind`=1, `ctr`=2'b11, `target`=`ex_target`. For JALR, this stores the last-seen target.
- A hit with `kind`=1 by a B-type (aliasing after tag overwrite cannot occur; the tag includes all upper bits) is treated as a hit and retrained. The B-type update writes `kind`=0.
- `mispredict_cnt` increments when `ex_valid && ex_flush`, and holds at all-ones.

## Timing
- Lookup is combinational from `if_pc` and registered table state: 0-cycle latency.
- Updates are written on the rising edge and are visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update (old) contents. There is no bypass.
- Reset (`rst_n`=0 at an edge):
  - All `valid` clear, all `ctr` go to 2'b01, `mispredict_cnt` goes to 0.
  - Tag and target contents are don't-care.
  - An update presented in the reset cycle is dropped.
- Outputs during and after reset: `pred_taken`=0 and `pred_target`=`if_pc+4` until the first allocation.
- Reset mid-stream discards all training. There is no partial state.

## Structure
- Shared package `rv_pkg`:
  - opcode constants `OP_BRANCH`, `OP_JAL`, `OP_JALR`
  - counter constants `CTR_SNT`=00, `CTR_WNT`=01, `CTR_WT`=10, `CTR_ST`=11
- One sub-module `sat_counter2`: 2-bit saturating up/down counter next-state function, instantiated per update path.
- Table is a register array with synchronous reset on `valid`/`ctr` only.

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104, `mispredict_cnt`=0.
- B-type at 0x100 resolved taken to 0x80 → next cycle lookup of 0x100 gives `pred_taken`=1, `pred_target`=0x80 (`ctr`=10). Then two not-taken updates → `pred_taken`=0 after the first, and `ctr`=00 after the second.
- JALR at 0x200 with targets 0x400 then 0x500 → lookup returns 0x400 then 0x500, always `pred_taken`=1. A B-type not-taken miss at 0x300 → no allocation.
- Alias: ENTRIES=16, taken branch at 0x100 then taken branch at 0x140 (same index, different tag) → lookup of 0x100 misses; 0x140 hits.
- Same-cycle update and lookup of 0x100 → old prediction is seen that cycle, new prediction the next. Assert `rst_n` during training → all lookups miss afterwards.
- With CNT_W=4: 20 cycles of `ex_valid && ex_flush` → `mispredict_cnt`=15 (saturated). `ex_flush` with `ex_valid`=0 → no increment.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline constants: opcodes used by branch resolution and
// the encodings of the 2-bit direction counters and table entry kinds.
package rv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        KIND_BRANCH = 1'b0,
        KIND_JUMP   = 1'b1
    } kind_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down direction counter.
module sat_counter2
    import rv_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped predictor: 2-bit counters plus BTB, zero-latency
// lookup, trained from EX resolution, with a saturating mispredict counter.
module branch_predictor
    import rv_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [6:0]       ex_opcode,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_flush,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic             kind_q   [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX-1:0]   if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;

    logic             wr_en_d;
    logic             kind_d;
    logic [1:0]       ctr_d, ctr_step;
    logic [31:0]      target_d;
    logic             unused_ex_pc_lsb;

    assign unused_ex_pc_lsb = ^ex_pc[1:0];

    assign if_idx = if_pc[IDX+1:2];
    assign if_tag = if_pc[31:IDX+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // No bypass: a same-cycle update to this index is seen only next cycle.
    assign pred_taken  = if_hit && (kind_q[if_idx] || ctr_q[if_idx][1]);
    assign pred_target = if_hit ? target_q[if_idx] : (if_pc + 32'd4);

    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[31:IDX+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    sat_counter2 u_sat (
        .ctr_i (ctr_q[ex_idx]),
        .inc_i (ex_taken),
        .ctr_o (ctr_step)
    );

    always_comb begin
        wr_en_d  = 1'b0;
        kind_d   = KIND_BRANCH;
        ctr_d    = ctr_step;
        target_d = ex_target;
        if (ex_valid) begin
            if ((ex_opcode == OP_JAL) || (ex_opcode == OP_JALR)) begin
                wr_en_d = 1'b1;
                kind_d  = KIND_JUMP;
                ctr_d   = CTR_ST;
            end else if (ex_opcode == OP_BRANCH) begin
                if (ex_hit) begin
                    wr_en_d = 1'b1;
                    if (!ex_taken) target_d = target_q[ex_idx];
                end else if (ex_taken) begin
                    wr_en_d = 1'b1;
                    ctr_d   = CTR_WT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (wr_en_d) begin
            valid_q[ex_idx] <= 1'b1;
            ctr_q[ex_idx]   <= ctr_d;
        end
    end

    // Payload fields carry no reset; valid_q masks them until reallocated.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_d) begin
            tag_q[ex_idx]    <= ex_tag;
            kind_q[ex_idx]   <= kind_d;
            target_q[ex_idx] <= target_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ex_valid && ex_flush && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random
// traffic, each cycle's expected lookup computed from an abstract table model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;

    localparam logic [6:0] BR   = 7'h63;
    localparam logic [6:0] JAL  = 7'h6F;
    localparam logic [6:0] JALR = 7'h67;
    localparam logic [6:0] ALU  = 7'h33;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ex_valid;
    logic [6:0]       ex_opcode;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             ex_flush;
    logic [CNT_W-1:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_flush       (ex_flush),
        .mispredict_cnt (mispredict_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: one record per table slot, strength as plain integer.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    bit          m_jump  [ENTRIES];
    int          m_str   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_str[i]   = 1;
        end
        m_cnt = 0;
    endfunction

    function automatic exp_t model_predict(input logic [31:0] pc);
        exp_t        e;
        int unsigned i;
        bit          hit;
        i        = (pc / 4) % ENTRIES;
        hit      = m_valid[i] && (m_tag[i] == pc / (4 * ENTRIES));
        e.pc     = pc;
        e.taken  = hit && (m_jump[i] || (m_str[i] >= 2));
        e.target = hit ? m_tgt[i] : pc + 32'd4;
        e.cnt    = m_cnt;
        return e;
    endfunction

    function automatic void model_update(input bit v, input logic [6:0] op,
                                         input logic [31:0] pc, input bit tk,
                                         input logic [31:0] tgt, input bit fl);
        int unsigned i, t;
        bit          hit;
        if (v && fl && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
        if (!v) return;
        i   = (pc / 4) % ENTRIES;
        t   = pc / (4 * ENTRIES);
        hit = m_valid[i] && (m_tag[i] == t);
        if (op == JAL || op == JALR) begin
            m_valid[i] = 1'b1; m_tag[i] = t; m_jump[i] = 1'b1; m_str[i] = 3; m_tgt[i] = tgt;
        end else if (op == BR) begin
            if (hit) begin
                m_jump[i] = 1'b0;
                m_str[i]  = tk ? ((m_str[i] == 3) ? 3 : m_str[i] + 1)
                               : ((m_str[i] == 0) ? 0 : m_str[i] - 1);
                if (tk) m_tgt[i] = tgt;
            end else if (tk) begin
                m_valid[i] = 1'b1; m_tag[i] = t; m_jump[i] = 1'b0; m_str[i] = 2; m_tgt[i] = tgt;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Monitor: compare the lookup presented in each cycle against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("pred_taken pc=%08h", e.pc), {31'b0, pred_taken}, {31'b0, e.taken});
                check($sformatf("pred_target pc=%08h", e.pc), pred_target, e.target);
                check($sformatf("mispredict_cnt pc=%08h", e.pc), {{(32-CNT_W){1'b0}}, mispredict_cnt}, e.cnt);
            end
        end
    end

    task automatic step(input bit rst, input logic [31:0] ifpc, input bit v,
                        input logic [6:0] op, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input bit fl, input bit chk);
        rst_n     = rst;
        if_pc     = ifpc;
        ex_valid  = v;
        ex_opcode = op;
        ex_pc     = pc;
        ex_taken  = tk;
        ex_target = tgt;
        ex_flush  = fl;
        if (chk) sb.push_back(model_predict(ifpc));
        @(posedge clk);
        if (!rst) model_reset();
        else      model_update(v, op, pc, tk, tgt, fl);
        #1;
    endtask

    task automatic look(input logic [31:0] ifpc);
        step(1'b1, ifpc, 1'b0, ALU, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [25:0] tag_pool [4];
        logic [31:0] rpc, rif;
        logic [6:0]  rop;
        int          sel;
        tag_pool[0] = 26'h4;
        tag_pool[1] = 26'h5;
        tag_pool[2] = 26'h3FFFFFF;
        tag_pool[3] = 26'h123456;
        model_reset();

        // Reset cycle with an update present: dropped, not checked (state unknown).
        step(1'b0, 32'h100, 1'b1, BR, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0);
        step(1'b0, 32'h100, 1'b1, BR, 32'h100, 1'b1, 32'h80, 1'b1, 1'b1);
        look(32'h100);
        // Taken branch allocates; same-cycle lookup sees the old miss.
        step(1'b1, 32'h100, 1'b1, BR, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b1, BR, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b1, BR, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b1, BR, 32'h100, 1'b1, 32'h84, 1'b0, 1'b1);
        look(32'h100);
        // JALR keeps the most recent target.
        step(1'b1, 32'h200, 1'b1, JALR, 32'h200, 1'b1, 32'h400, 1'b0, 1'b1);
        step(1'b1, 32'h200, 1'b1, JALR, 32'h200, 1'b1, 32'h500, 1'b0, 1'b1);
        look(32'h200);
        step(1'b1, 32'h300, 1'b1, BR, 32'h300, 1'b0, 32'h0, 1'b0, 1'b1);
        look(32'h300);
        // Alias at index 0: 0x140 evicts 0x100.
        step(1'b1, 32'h140, 1'b1, BR, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b1, BR, 32'h140, 1'b1, 32'h90, 1'b0, 1'b1);
        look(32'h100);
        look(32'h140);
        step(1'b1, 32'h140, 1'b1, ALU, 32'h140, 1'b1, 32'h44, 1'b0, 1'b1);
        step(1'b1, 32'h140, 1'b0, JAL, 32'h140, 1'b1, 32'h48, 1'b0, 1'b1);
        step(1'b1, 32'h140, 1'b1, JAL, 32'h104, 1'b1, 32'h1000, 1'b0, 1'b1);
        look(32'h104);
        // Mid-stream reset discards all training.
        step(1'b0, 32'h140, 1'b1, JAL, 32'h140, 1'b1, 32'h48, 1'b1, 1'b1);
        look(32'h140);
        look(32'h200);
        look(32'h104);
        // Mispredict counter saturation and gating by ex_valid.
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'h10, 1'b1, ALU, 32'h10, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h10, 1'b0, ALU, 32'h10, 1'b0, 32'h0, 1'b1, 1'b1);
        look(32'h10);
        step(1'b0, 32'h10, 1'b0, ALU, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h10, 1'b0, ALU, 32'h10, 1'b0, 32'h0, 1'b1, 1'b1);

        for (int n = 0; n < 600; n++) begin
            rpc = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            rif = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            sel = $urandom_range(0, 9);
            rop = (sel < 5) ? BR : (sel < 7) ? JAL : (sel < 9) ? JALR : ALU;
            if ($urandom_range(0, 2) == 0) rif = rpc;
            step(($urandom_range(0, 79) != 0), rif, ($urandom_range(0, 4) != 0), rop, rpc,
                 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 5) == 0), 1'b1);
        end

        @(negedge clk);
        #1;
        check("scoreboard drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
